// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared combinational ALU.
// Two requesters compete for the ALU. The winning operands are registered onto the
// ALU inputs and held for EXEC_CYCLES cycles. The result and flags are then captured
// and returned on a single response channel tagged with the requester id.
module alu_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,

    // Requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,

    // Requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,

    // Shared ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_cntr,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carryout,
    input  logic             alu_negative,

    // Response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,

    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    // The settle counter runs from EXEC_CYCLES-1 down to 0; 4 bits cover the 1..15 range.
    localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cur_id_q, cur_id_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_cntr_q, alu_cntr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;

    logic             any_valid;
    logic             grant_id;
    logic             accept;

    // Round-robin pick: a lone requester always wins; a tie goes to the one not served last.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Ready is only offered in IDLE, never in a reset cycle, and only to the granted side.
    always_comb begin
        accept     = (state_q == StIdle) && !reset && any_valid;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    // Next-state and datapath updates for the three-phase transaction.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        cur_id_d     = cur_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cntr_d   = alu_cntr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    alu_a_d      = grant_id ? req1_a  : req0_a;
                    alu_b_d      = grant_id ? req1_b  : req0_b;
                    alu_cntr_d   = grant_id ? req1_op : req0_op;
                    cur_id_d     = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = CntLoad;
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = alu_out;
                    rsp_flags_d = {alu_zero, alu_overflow, alu_carryout, alu_negative};
                    rsp_id_d    = cur_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; synchronous reset discards any in-flight operation or response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            cur_id_q     <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cntr_q   <= 2'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            cur_id_q     <= cur_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cntr_q   <= alu_cntr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cntr  = alu_cntr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter. A slow ALU model only settles after its inputs
// have been stable for EXEC-1 cycles. A transaction-timeline reference model predicts
// every output each cycle.
module tb_alu_arbiter;

    localparam int unsigned W    = 32;
    localparam int unsigned EXEC = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [1:0]   alu_cntr;
    logic         alu_zero, alu_overflow, alu_carryout, alu_negative;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(EXEC)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cntr     (alu_cntr),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carryout (alu_carryout),
        .alu_negative (alu_negative),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags),
        .busy         (busy)
    );

    // ALU function: op 0 ADD, 1 SUB, 2 NOR, 3 SLTU. Result is {zero, ovf, carry, neg, value}.
    function automatic logic [W+3:0] alu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            2'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            2'd2: r = ~(a | b);
            default: r = {{(W-1){1'b0}}, (a < b)};
        endcase
        return {(r == '0), v, c, r[W-1], r};
    endfunction

    // Slow ALU: shows inverted garbage until its inputs have been stable long enough.
    int              age = 0;
    logic [2*W+1:0]  prev_in = '0;
    logic [W+3:0]    settled;

    always @(negedge clk) begin
        if ({alu_a, alu_b, alu_cntr} != prev_in) age <= 0;
        else if (age < 1000) age <= age + 1;
        prev_in <= {alu_a, alu_b, alu_cntr};
    end

    always_comb begin
        settled = alu_calc(alu_a, alu_b, alu_cntr);
        if (age < int'(EXEC) - 1) settled = ~settled;
        {alu_zero, alu_overflow, alu_carryout, alu_negative, alu_out} = settled;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: one transaction at a time, described by cycles since acceptance.
    bit           m_busy      = 1'b0;
    int           m_k         = 0;
    bit           m_last      = 1'b1;
    logic [W-1:0] m_a         = '0;
    logic [W-1:0] m_b         = '0;
    logic [1:0]   m_op        = 2'd0;
    logic [W+3:0] m_res       = '0;
    bit           m_id        = 1'b0;
    bit           m_rsp_valid = 1'b0;
    bit           m_rsp_id    = 1'b0;
    logic [W-1:0] m_rsp_data  = '0;
    logic [3:0]   m_rsp_flags = 4'd0;

    // One clock: check all outputs mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        bit e0, e1;
        @(negedge clk);
        e0 = !reset && !m_busy && req0_valid && (!req1_valid || m_last);
        e1 = !reset && !m_busy && req1_valid && (!req0_valid || !m_last);
        check_eq("req0_ready", 64'(req0_ready), 64'(e0));
        check_eq("req1_ready", 64'(req1_ready), 64'(e1));
        check_eq("busy",       64'(busy),       64'(m_busy));
        check_eq("rsp_valid",  64'(rsp_valid),  64'(m_rsp_valid));
        check_eq("rsp_id",     64'(rsp_id),     64'(m_rsp_id));
        check_eq("rsp_data",   64'(rsp_data),   64'(m_rsp_data));
        check_eq("rsp_flags",  64'(rsp_flags),  64'(m_rsp_flags));
        check_eq("alu_a",      64'(alu_a),      64'(m_a));
        check_eq("alu_b",      64'(alu_b),      64'(m_b));
        check_eq("alu_cntr",   64'(alu_cntr),   64'(m_op));

        if (reset) begin
            m_busy = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_op = 2'd0;
            m_rsp_valid = 1'b0; m_rsp_id = 1'b0; m_rsp_data = '0; m_rsp_flags = 4'd0;
        end else if (!m_busy) begin
            if (e0 || e1) begin
                m_id   = e1;
                m_a    = e1 ? req1_a  : req0_a;
                m_b    = e1 ? req1_b  : req0_b;
                m_op   = e1 ? req1_op : req0_op;
                m_res  = alu_calc(m_a, m_b, m_op);
                m_last = m_id;
                m_busy = 1'b1;
                m_k    = 1;
            end
        end else if (!m_rsp_valid) begin
            if (m_k == int'(EXEC)) begin
                m_rsp_valid = 1'b1;
                m_rsp_id    = m_id;
                m_rsp_data  = m_res[W-1:0];
                m_rsp_flags = m_res[W+3:W];
            end
            m_k++;
        end else if (rsp_ready) begin
            m_rsp_valid = 1'b0;
            m_busy      = 1'b0;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'd0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'd0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Single ADD from requester 0.
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 2'd0;
        rsp_ready  = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (EXEC) tick();
        check_eq("single_valid", 64'(rsp_valid), 64'd1);
        check_eq("single_id",    64'(rsp_id),    64'd0);
        check_eq("single_data",  64'(rsp_data),  64'd8);
        check_eq("single_flags", 64'(rsp_flags), 64'd0);
        tick();
        check_eq("single_idle",  64'(busy),      64'd0);

        // Continuous tie: grants must alternate; requester 1 computes 7-7.
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 2'd0;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_op = 2'd1;
        repeat (4 * (EXEC + 2)) tick();

        // Back-pressure: consumer accepts only every 12th cycle while both requesters wait.
        for (int i = 0; i < 72; i++) begin
            req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom_range(0, 3));
            req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom_range(0, 3));
            rsp_ready = (i % 12 == 11);
            tick();
        end

        // Reset during EXEC, then during RESP; requester 0 must win the tie afterwards.
        rsp_ready = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        repeat (EXEC + 2) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        rsp_ready = 1'b1;
        repeat (EXEC + 4) tick();

        // Random traffic with operands churning every cycle and occasional resets.
        for (int i = 0; i < 800; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a  = $urandom;
            req0_b  = ($urandom_range(0, 7) == 0) ? req0_a : $urandom;
            req0_op = 2'($urandom_range(0, 3));
            req1_a  = $urandom;
            req1_b  = ($urandom_range(0, 7) == 0) ? req1_a : $urandom;
            req1_op = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (ADD/SUB/NOR/SLTU, with zero/overflow/carryout/negative flags) between two requesters.
- Arbitrates round-robin and registers the selected operands onto the ALU inputs.
- Waits a programmable settle time, captures the ALU result and flags, and returns them on a single response channel tagged with the requester id.
- Sits between the issue/execute logic and the shared ALU instance.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- EXEC_CYCLES, 1, cycles the ALU inputs are held stable before the result is sampled; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_op  input  2  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- alu_a, alu_b  output  WIDTH  registered operands driven to the ALU.
- alu_cntr  output  2  registered ALU control code.
- alu_out  input  WIDTH  ALU result.
- alu_zero, alu_overflow, alu_carryout, alu_negative  input  1 each  ALU flags.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the operation.
- rsp_data  output  WIDTH  captured ALU result.
- rsp_flags  output  4  captured flags {zero, overflow, carryout, negative}.
- busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - alu_a = alu_b = 0, alu_cntr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_flags = 0.
  - req*_ready = 0, busy = 0.
  - Reset mid-operation discards the in-flight op and any pending response; no ready is issued in the reset cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready are combinational and asserted only in IDLE, for the granted requester only.
  - Grant rules: if exactly one reqN_valid, grant N. If both, grant the requester that is not last_grant (round-robin).
  - The handshake completes in the same cycle (valid and ready both high). On that edge: latch the granted a/b/op into alu_a/alu_b/alu_cntr, latch the id, set last_grant = id, load the counter with EXEC_CYCLES-1, go to EXEC.
  - No valid: stay in IDLE; ALU input registers hold their previous values.
- EXEC:
  - ALU inputs are held constant. The counter decrements each cycle.
  - In the cycle the counter is 0: capture alu_out into rsp_data, the flags into rsp_flags, and the id into rsp_id; set rsp_valid; go to RESP.
  - EXEC therefore lasts exactly EXEC_CYCLES cycles.
- RESP:
  - rsp_valid = 1. rsp_* and alu_* are held stable until rsp_ready is high.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
  - No new request is accepted in RESP, including the handshake cycle.
  - rsp_ready low holds indefinitely (back-pressure); requesters see ready = 0 throughout.
- Latency: accept at cycle T, rsp_valid first high at T+EXEC_CYCLES+1. Best-case throughput is one op per EXEC_CYCLES+2 cycles.
- Requesters may change operands or drop valid at any time before the handshake; only values present at the handshake edge are used.
- The arbiter does not interpret op codes or flags; it passes them through unchanged.
- busy = (state != IDLE).

Test Plan:
- Single op: EXEC_CYCLES=1, req0 a=5 b=3 op=ADD at T, rsp_ready=1 -> req0_ready high at T; rsp_valid at T+2 with rsp_id=0, rsp_data=8, flags zero=0 negative=0; back in IDLE at T+3.
- Tie and round-robin: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 across four ops; each rsp_id matches the issuing requester's operands (req1 a=7 b=7 op=SUB -> rsp_data=0, zero=1).
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data/rsp_flags/alu_* stable; req0_ready and req1_ready stay 0 although both are valid; rsp_ready=1 -> next grant in the following IDLE cycle.
- Settle time: EXEC_CYCLES=4; the ALU model changes alu_out only after inputs have been stable 3 cycles -> captured value is the settled value; rsp_valid exactly 5 cycles after accept.
- Reset mid-op: assert reset during EXEC and again during RESP -> the next cycle shows rsp_valid=0, busy=0, alu_* = 0; with both requesters valid afterwards, req0 wins first.
- Operand churn: req1 changes a/b every cycle while waiting for ready -> the response uses only the values present at the handshake edge.
